// File: rtl/uart_conf_bank_if.sv
// Request/acknowledge port of the UART configuration bank.
// Master issues addressed reads/writes, slave acknowledges.
interface uart_conf_bank_if #(
    parameter int CONFIG_WIDTH = 32,
    parameter int ADDR_WIDTH   = 2
);
    logic                    conf_req;
    logic                    conf_we;
    logic [ADDR_WIDTH-1:0]   conf_addr;
    logic [CONFIG_WIDTH-1:0] conf_in;
    logic                    conf_ack;
    logic                    conf_err;
    logic [CONFIG_WIDTH-1:0] conf_rdata;

    modport master (
        output conf_req,
        output conf_we,
        output conf_addr,
        output conf_in,
        input  conf_ack,
        input  conf_err,
        input  conf_rdata
    );

    modport slave (
        input  conf_req,
        input  conf_we,
        input  conf_addr,
        input  conf_in,
        output conf_ack,
        output conf_err,
        output conf_rdata
    );
endinterface

// File: rtl/uart_conf_bank.sv
// Bank of UART configuration registers with addressed write/read-back.
// Accept, commit, then wait for request release before the next accept.
module uart_conf_bank #(
    parameter int CONFIG_WIDTH = 32,
    parameter int NUM_REGS     = 4,
    parameter int ADDR_WIDTH   = 2,
    parameter logic [NUM_REGS*CONFIG_WIDTH-1:0] RESET_VALUE =
        {NUM_REGS{32'h00000062}}
) (
    input  logic                             clock,
    input  logic                             reset,
    uart_conf_bank_if.slave                  bus,
    output logic [NUM_REGS*CONFIG_WIDTH-1:0] conf_out,
    output logic [NUM_REGS-1:0]              conf_upd
);

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        RELEASE
    } state_t;

    state_t                  state;
    logic                    sh_we;
    logic [ADDR_WIDTH-1:0]   sh_addr;
    logic [CONFIG_WIDTH-1:0] sh_data;
    logic [CONFIG_WIDTH-1:0] regs [NUM_REGS];

    logic                    in_range;
    logic [CONFIG_WIDTH-1:0] rd_mux;

    // Loop-based decode keeps out-of-range addresses from indexing regs.
    always_comb begin
        in_range = 1'b0;
        rd_mux   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.conf_addr == ADDR_WIDTH'(i)) begin
                in_range = 1'b1;
                rd_mux   = regs[i];
            end
        end
    end

    always_comb begin
        conf_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            conf_out[i*CONFIG_WIDTH +: CONFIG_WIDTH] = regs[i];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            sh_we          <= 1'b0;
            sh_addr        <= '0;
            sh_data        <= '0;
            bus.conf_ack   <= 1'b0;
            bus.conf_err   <= 1'b0;
            bus.conf_rdata <= '0;
            conf_upd       <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALUE[i*CONFIG_WIDTH +: CONFIG_WIDTH];
            end
        end else begin
            conf_upd <= '0;
            case (state)
                IDLE: begin
                    if (bus.conf_req) begin
                        sh_we          <= bus.conf_we;
                        sh_addr        <= bus.conf_addr;
                        sh_data        <= bus.conf_in;
                        bus.conf_err   <= !in_range;
                        bus.conf_rdata <= rd_mux;
                        bus.conf_ack   <= 1'b1;
                        state          <= ACK;
                    end
                end
                ACK: begin
                    bus.conf_ack <= 1'b0;
                    if (bus.conf_req) begin
                        // conf_err still holds the accept-time range check.
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (sh_we && !bus.conf_err &&
                                sh_addr == ADDR_WIDTH'(i)) begin
                                regs[i]     <= sh_data;
                                conf_upd[i] <= 1'b1;
                            end
                        end
                        state <= RELEASE;
                    end else begin
                        state <= IDLE;
                    end
                end
                RELEASE: begin
                    if (!bus.conf_req) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
